// File: rtl/cache_mem_arbiter.sv
// Two-requester (I-cache / D-cache) refill arbiter in front of a single DRAM read port.
// Round-robin tie-break, per-request WAIT timeout, and every output registered.
module cache_mem_arbiter #(
    parameter int LineSize       = 128,
    parameter int ByteOffsetBits = 4,
    parameter int TimeoutCycles  = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_read_en_i,
    input  logic [31:0]         req0_addr_i,
    output logic                req0_read_valid_o,
    output logic [LineSize-1:0] req0_read_data_o,
    input  logic                req1_read_en_i,
    input  logic [31:0]         req1_addr_i,
    output logic                req1_read_valid_o,
    output logic [LineSize-1:0] req1_read_data_o,
    output logic                mem_read_en_o,
    output logic [31:0]         mem_addr_o,
    input  logic                mem_read_valid_i,
    input  logic [LineSize-1:0] mem_read_data_i,
    output logic [1:0]          grant_o,
    output logic                busy_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [31:0] LineMask = ~((32'd1 << ByteOffsetBits) - 32'd1);
    localparam logic [7:0]  CntLast  = 8'(TimeoutCycles - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        owner;       // 0 = req0, 1 = req1
    logic        last_grant;
    logic        win;
    logic [31:0] win_addr;

    // req1 wins when it is the only requester, or on a tie when req0 was served last.
    always_comb begin
        win      = req1_read_en_i & (~req0_read_en_i | ~last_grant);
        win_addr = win ? req1_addr_i : req0_addr_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            cnt               <= '0;
            owner             <= 1'b0;
            last_grant        <= 1'b1;
            mem_read_en_o     <= 1'b0;
            mem_addr_o        <= '0;
            req0_read_valid_o <= 1'b0;
            req1_read_valid_o <= 1'b0;
            req0_read_data_o  <= '0;
            req1_read_data_o  <= '0;
            grant_o           <= 2'b00;
            busy_o            <= 1'b0;
            timeout_o         <= 1'b0;
        end else begin
            req0_read_valid_o <= 1'b0;
            req1_read_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_read_en_i | req1_read_en_i) begin
                        owner         <= win;
                        grant_o       <= win ? 2'b10 : 2'b01;
                        mem_addr_o    <= win_addr & LineMask;
                        mem_read_en_o <= 1'b1;
                        cnt           <= '0;
                        busy_o        <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // DRAM valid takes priority over a timeout landing on the same edge.
                    if (mem_read_valid_i) begin
                        if (owner) begin
                            req1_read_data_o  <= mem_read_data_i;
                            req1_read_valid_o <= 1'b1;
                        end else begin
                            req0_read_data_o  <= mem_read_data_i;
                            req0_read_valid_o <= 1'b1;
                        end
                        mem_read_en_o <= 1'b0;
                        state         <= DONE;
                    end else if (cnt == CntLast) begin
                        cnt           <= cnt + 8'd1;
                        timeout_o     <= 1'b1;
                        mem_read_en_o <= 1'b0;
                        grant_o       <= 2'b00;
                        busy_o        <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    last_grant <= owner;
                    grant_o    <= 2'b00;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed vector table, timeout/reset sequences,
// then random traffic scored against a transaction-level reference model.
module tb_cache_mem_arbiter;

    localparam int LS = 128;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0, r1, mv;
    logic [31:0]   a0, a1;
    logic [LS-1:0] md;
    logic          v0, v1, en, busy, to;
    logic [LS-1:0] d0, d1;
    logic [31:0]   ad;
    logic [1:0]    gnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.LineSize(LS), .ByteOffsetBits(4), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_read_en_i(r0), .req0_addr_i(a0), .req0_read_valid_o(v0), .req0_read_data_o(d0),
        .req1_read_en_i(r1), .req1_addr_i(a1), .req1_read_valid_o(v1), .req1_read_data_o(d1),
        .mem_read_en_o(en), .mem_addr_o(ad), .mem_read_valid_i(mv), .mem_read_data_i(md),
        .grant_o(gnt), .busy_o(busy), .timeout_o(to)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_en, input logic [31:0] e_ad,
                             input logic [1:0] e_g, input logic e_v0, input logic e_v1,
                             input logic [LS-1:0] e_d0, input logic [LS-1:0] e_d1,
                             input logic e_b, input logic e_to);
        check({tag, " en"}, 128'(en), 128'(e_en));
        check({tag, " addr"}, 128'(ad), 128'(e_ad));
        check({tag, " grant"}, 128'(gnt), 128'(e_g));
        check({tag, " v0"}, 128'(v0), 128'(e_v0));
        check({tag, " v1"}, 128'(v1), 128'(e_v1));
        check({tag, " d0"}, d0, e_d0);
        check({tag, " d1"}, d1, e_d1);
        check({tag, " busy"}, 128'(busy), 128'(e_b));
        check({tag, " timeout"}, 128'(to), 128'(e_to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst, r0, r1;
        logic [31:0]   a0, a1;
        logic          mv;
        logic [LS-1:0] md;
        logic          en;
        logic [31:0]   ad;
        logic [1:0]    g;
        logic          v0, v1;
        logic [LS-1:0] d0, d1;
        logic          b, to;
    } vec_t;

    function automatic vec_t mk(logic rs, logic q0, logic q1, logic [31:0] x0, logic [31:0] x1,
                                logic m, logic [LS-1:0] mdat, logic e, logic [31:0] ea,
                                logic [1:0] eg, logic ev0, logic ev1, logic [LS-1:0] ed0,
                                logic [LS-1:0] ed1, logic eb, logic eto);
        vec_t t;
        t.rst = rs; t.r0 = q0; t.r1 = q1; t.a0 = x0; t.a1 = x1; t.mv = m; t.md = mdat;
        t.en = e; t.ad = ea; t.g = eg; t.v0 = ev0; t.v1 = ev1; t.d0 = ed0; t.d1 = ed1;
        t.b = eb; t.to = eto;
        return t;
    endfunction

    // Reference model: one outstanding transaction, tracked by owner and age.
    int            m_owner;   // -1 when nobody owns the port
    bit            m_done;
    int            m_waited;
    int            m_last;
    logic          m_en, m_b, m_to;
    logic [31:0]   m_ad;
    logic          m_v[2];
    logic [LS-1:0] m_d[2];

    task automatic model_reset();
        m_owner = -1; m_done = 0; m_waited = 0; m_last = 1;
        m_en = 0; m_b = 0; m_to = 0; m_ad = 0;
        m_v[0] = 0; m_v[1] = 0; m_d[0] = '0; m_d[1] = '0;
    endtask

    task automatic model_step();
        int pick;
        m_v[0] = 0; m_v[1] = 0;
        if (m_owner < 0) begin
            if (r0 || r1) begin
                if (r0 && r1) pick = 1 - m_last;
                else          pick = r1 ? 1 : 0;
                m_owner = pick; m_waited = 0; m_done = 0;
                m_ad = ((pick == 1) ? a1 : a0) / 16 * 16;
                m_en = 1; m_b = 1;
            end
        end else if (m_done) begin
            m_last = m_owner; m_owner = -1; m_done = 0; m_b = 0;
        end else if (mv) begin
            m_d[m_owner] = md; m_v[m_owner] = 1; m_en = 0; m_done = 1;
        end else begin
            m_waited++;
            if (m_waited >= TO) begin
                m_to = 1; m_en = 0; m_owner = -1; m_b = 0;
            end
        end
    endtask

    localparam logic [LS-1:0] D1 = 128'hDEADBEEF_01234567_89ABCDEF_BEEFDEAD;
    localparam logic [LS-1:0] D2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [LS-1:0] D3 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [LS-1:0] D4 = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    localparam logic [LS-1:0] SX = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(0,1,0,32'h414,0,0,0,   1,32'h410,2'b01,0,0,'0,'0,1,0);
        vecs[1]  = mk(0,1,0,32'h440,0,0,0,   1,32'h410,2'b01,0,0,'0,'0,1,0);
        vecs[2]  = mk(0,1,0,32'h440,0,0,0,   1,32'h410,2'b01,0,0,'0,'0,1,0);
        vecs[3]  = mk(0,1,0,32'h440,0,1,D1,  0,32'h410,2'b01,1,0,D1,'0,1,0);
        vecs[4]  = mk(0,0,0,32'h440,0,0,0,   0,32'h410,2'b00,0,0,D1,'0,0,0);
        vecs[5]  = mk(0,0,0,0,0,1,SX,        0,32'h410,2'b00,0,0,D1,'0,0,0);
        vecs[6]  = mk(0,0,0,0,0,0,0,         0,32'h410,2'b00,0,0,D1,'0,0,0);
        vecs[7]  = mk(1,0,0,0,0,0,0,         0,0,2'b00,0,0,'0,'0,0,0);
        vecs[8]  = mk(0,1,1,32'h414,32'h818,0,0,  1,32'h410,2'b01,0,0,'0,'0,1,0);
        vecs[9]  = mk(0,1,1,32'h414,32'h818,0,0,  1,32'h410,2'b01,0,0,'0,'0,1,0);
        vecs[10] = mk(0,1,1,32'h414,32'h818,1,D2, 0,32'h410,2'b01,1,0,D2,'0,1,0);
        vecs[11] = mk(0,1,1,32'h414,32'h818,0,0,  0,32'h410,2'b00,0,0,D2,'0,0,0);
        vecs[12] = mk(0,1,1,32'h414,32'h818,0,0,  1,32'h810,2'b10,0,0,D2,'0,1,0);
        vecs[13] = mk(0,1,0,32'h414,32'h818,0,0,  1,32'h810,2'b10,0,0,D2,'0,1,0);
        vecs[14] = mk(0,1,0,32'h414,32'h818,1,D3, 0,32'h810,2'b10,0,1,D2,D3,1,0);
        vecs[15] = mk(0,1,1,32'h414,32'h818,0,0,  0,32'h810,2'b00,0,0,D2,D3,0,0);
        vecs[16] = mk(0,1,1,32'h414,32'h818,0,0,  1,32'h410,2'b01,0,0,D2,D3,1,0);
        vecs[17] = mk(0,1,1,32'h414,32'h818,1,D4, 0,32'h410,2'b01,1,0,D4,D3,1,0);
        vecs[18] = mk(0,0,0,32'h414,32'h818,0,0,  0,32'h410,2'b00,0,0,D4,D3,0,0);

        rst = 1; r0 = 0; r1 = 0; mv = 0; a0 = 0; a1 = 0; md = '0;
        #1;
        check_all("reset", 0, 0, 2'b00, 0, 0, '0, '0, 0, 0);
        tick(); tick();
        rst = 0;

        // Directed vectors: single request, address stability, stray valid, ties, drop in WAIT.
        for (int i = 0; i < 19; i++) begin
            rst = vecs[i].rst; r0 = vecs[i].r0; r1 = vecs[i].r1;
            a0 = vecs[i].a0; a1 = vecs[i].a1; mv = vecs[i].mv; md = vecs[i].md;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].ad, vecs[i].g,
                      vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1, vecs[i].b, vecs[i].to);
        end
        rst = 0; r0 = 0; r1 = 0; mv = 0;

        // Timeout: four silent WAIT cycles, then the still-pending request is reissued.
        rst = 1; tick(); rst = 0;
        r0 = 1; a0 = 32'h414;
        tick();
        check("to_req en", 128'(en), 128'(1));
        for (int k = 1; k < TO; k++) begin
            tick();
            check($sformatf("to_wait%0d en", k), 128'(en), 128'(1));
            check($sformatf("to_wait%0d timeout", k), 128'(to), 128'(0));
        end
        tick();
        check("to_hit timeout", 128'(to), 128'(1));
        check("to_hit en", 128'(en), 128'(0));
        check("to_hit busy", 128'(busy), 128'(0));
        check("to_hit grant", 128'(gnt), 128'(0));
        check("to_hit v0", 128'(v0), 128'(0));
        tick();
        check("to_reissue en", 128'(en), 128'(1));
        check("to_reissue addr", 128'(ad), 128'(32'h410));
        check("to_reissue grant", 128'(gnt), 128'(2'b01));
        mv = 1; md = D1;
        tick();
        check("to_done v0", 128'(v0), 128'(1));
        check("to_done d0", d0, D1);
        check("to_done sticky", 128'(to), 128'(1));
        mv = 0; r0 = 0;
        tick();
        check("to_after sticky", 128'(to), 128'(1));

        // Valid on the same edge the counter would expire: valid wins.
        rst = 1; tick(); rst = 0;
        r0 = 1; a0 = 32'h414;
        tick();
        for (int k = 1; k < TO; k++) tick();
        mv = 1; md = D2;
        tick();
        check("race v0", 128'(v0), 128'(1));
        check("race d0", d0, D2);
        check("race timeout", 128'(to), 128'(0));
        check("race en", 128'(en), 128'(0));
        mv = 0; r0 = 0;
        tick();

        // Reset mid-WAIT clears outputs immediately; a late DRAM valid is ignored.
        r0 = 1; a0 = 32'h414;
        tick(); tick();
        check("rstw pre en", 128'(en), 128'(1));
        @(negedge clk);
        rst = 1;
        #1;
        check_all("rstw async", 0, 0, 2'b00, 0, 0, '0, '0, 0, 0);
        tick();
        rst = 0; r0 = 0; mv = 1; md = D3;
        tick();
        check_all("rstw late", 0, 0, 2'b00, 0, 0, '0, '0, 0, 0);
        mv = 0;

        // Random traffic against the reference model.
        rst = 1; tick(); rst = 0;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            r0 = ($urandom_range(0, 99) < 55);
            r1 = ($urandom_range(0, 99) < 55);
            a0 = $urandom; a1 = $urandom;
            mv = ($urandom_range(0, 99) < 35);
            md = {$urandom, $urandom, $urandom, $urandom};
            model_step();
            tick();
            check_all($sformatf("rnd%0d", c), m_en, m_ad, (m_owner < 0) ? 2'b00 : 2'(1 << m_owner),
                      m_v[0], m_v[1], m_d[0], m_d[1], m_b, m_to);
            if (($urandom_range(0, 199) == 0)) begin
                rst = 1; tick(); rst = 0; model_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
